// File: rtl/bnn_pkg.sv
// Shared types and sizes for the binary neural network sequencer.
package bnn_pkg;

    localparam int unsigned BNN_IN_BITS    = 8;
    localparam int unsigned BNN_OUT_BITS   = 8;
    localparam int unsigned BNN_NIBBLE     = 4;
    localparam int unsigned BNN_CHAIN_BITS = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_X_LO,
        S_X_HI,
        S_WAIT,
        S_HOLD
    } bnn_seq_state_t;

endpackage

// File: rtl/bnn_param_serializer.sv
// Byte-to-bit shifter for the datapath parameter chain, LSB first, limited to CHAIN_BITS bits.
module bnn_param_serializer #(
    parameter int unsigned CHAIN_BITS = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       shift_en,
    output logic       bit_out,
    output logic       last_c
);

    localparam int unsigned CW = $clog2(CHAIN_BITS + 1);

    logic [CW-1:0] remaining;
    logic [6:0]    shreg;
    logic [2:0]    byte_left;
    logic [3:0]    take_c;
    logic          accept_c;

    // Bits taken from the next byte: a full byte, or whatever is left of the chain.
    always_comb begin
        take_c   = (32'(remaining) >= 32'd8) ? 4'd8 : 4'(remaining);
        accept_c = in_valid & in_ready;
        last_c   = shift_en & (byte_left == 3'd0) & (remaining == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            shreg     <= '0;
            byte_left <= '0;
            in_ready  <= 1'b0;
            shift_en  <= 1'b0;
            bit_out   <= 1'b0;
        end else if (start) begin
            remaining <= CW'(CHAIN_BITS);
            shreg     <= '0;
            byte_left <= '0;
            in_ready  <= 1'b1;
            shift_en  <= 1'b0;
        end else if (accept_c) begin
            in_ready  <= 1'b0;
            shift_en  <= 1'b1;
            bit_out   <= in_data[0];
            shreg     <= in_data[7:1];
            byte_left <= 3'(take_c - 4'd1);
            remaining <= remaining - CW'(take_c);
        end else if (shift_en) begin
            if (byte_left != 3'd0) begin
                bit_out   <= shreg[0];
                shreg     <= {1'b0, shreg[6:1]};
                byte_left <= byte_left - 3'd1;
            end else begin
                shift_en <= 1'b0;
                in_ready <= (remaining != '0);
            end
        end
    end

endmodule

// File: rtl/bnn_sequencer.sv
// Sequences parameter loading and nibble-wise inference for the binary neural network datapath.
module bnn_sequencer
    import bnn_pkg::*;
#(
    parameter int unsigned CHAIN_BITS = BNN_CHAIN_BITS,
    parameter int unsigned SETTLE     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_start,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [7:0]              cfg_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BNN_IN_BITS-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BNN_OUT_BITS-1:0] out_data,
    output logic                    busy,
    output logic                    loaded,
    output logic                    bnn_setup,
    output logic                    bnn_param_in,
    output logic                    bnn_x_bank_hi,
    output logic [BNN_NIBBLE-1:0]   bnn_x,
    input  logic [BNN_OUT_BITS-1:0] bnn_out
);

    localparam int unsigned WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    bnn_seq_state_t         state;
    logic [BNN_IN_BITS-1:0] in_lat;
    logic [WW-1:0]          wait_cnt;
    logic                   start_c;
    logic                   last_c;

    assign start_c = (state == S_IDLE) & load_start;

    bnn_param_serializer #(
        .CHAIN_BITS(CHAIN_BITS)
    ) u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_c),
        .in_valid (cfg_valid),
        .in_ready (cfg_ready),
        .in_data  (cfg_data),
        .shift_en (bnn_setup),
        .bit_out  (bnn_param_in),
        .last_c   (last_c)
    );

    // Outside X_LO the nibble pins keep presenting the latched high nibble with bank_hi set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            loaded        <= 1'b0;
            busy          <= 1'b0;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            bnn_x_bank_hi <= 1'b1;
            bnn_x         <= '0;
            in_lat        <= '0;
            wait_cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_start) begin
                        state    <= S_LOAD;
                        busy     <= 1'b1;
                        loaded   <= 1'b0;
                        in_ready <= 1'b0;
                    end else if (in_valid && in_ready) begin
                        state         <= S_X_LO;
                        busy          <= 1'b1;
                        in_ready      <= 1'b0;
                        in_lat        <= in_data;
                        bnn_x         <= in_data[BNN_NIBBLE-1:0];
                        bnn_x_bank_hi <= 1'b0;
                    end else begin
                        in_ready <= loaded & ~out_valid;
                    end
                end
                S_LOAD: begin
                    if (last_c) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        loaded   <= 1'b1;
                        in_ready <= ~out_valid;
                    end
                end
                S_X_LO: begin
                    state         <= S_X_HI;
                    bnn_x         <= in_lat[BNN_IN_BITS-1 -: BNN_NIBBLE];
                    bnn_x_bank_hi <= 1'b1;
                end
                S_X_HI: begin
                    state    <= S_WAIT;
                    wait_cnt <= WW'(SETTLE - 1);
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state     <= S_HOLD;
                        out_data  <= bnn_out;
                        out_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - WW'(1);
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        in_ready  <= loaded;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_sequencer.sv
// Directed bench for bnn_sequencer: 16-bit and 12-bit chain loads, inference, gating and reset.
module tb_bnn_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_start, cfg_valid, in_valid, out_ready;
    logic [7:0] cfg_data, in_data, bnn_out;
    logic       cfg_ready, in_ready, out_valid, busy, loaded;
    logic       bnn_setup, bnn_param_in, bnn_x_bank_hi;
    logic [7:0] out_data;
    logic [3:0] bnn_x;

    logic       ld12, cv12;
    logic [7:0] cd12;
    logic       cr12, ir12, ov12, busy12, loaded12, set12, pin12, bank12;
    logic [7:0] od12;
    logic [3:0] x12;

    int n_chk = 0;
    int n_pass = 0;
    int nset16 = 0;
    int nset12 = 0;
    int gap_bad = 0;
    logic q16[$];
    logic q12[$];

    always #5 clk = ~clk;

    bnn_sequencer #(.CHAIN_BITS(16), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .loaded(loaded), .bnn_setup(bnn_setup), .bnn_param_in(bnn_param_in),
        .bnn_x_bank_hi(bnn_x_bank_hi), .bnn_x(bnn_x), .bnn_out(bnn_out)
    );

    bnn_sequencer #(.CHAIN_BITS(12), .SETTLE(1)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .load_start(ld12),
        .cfg_valid(cv12), .cfg_ready(cr12), .cfg_data(cd12),
        .in_valid(1'b0), .in_ready(ir12), .in_data(8'h00),
        .out_valid(ov12), .out_ready(1'b0), .out_data(od12),
        .busy(busy12), .loaded(loaded12), .bnn_setup(set12), .bnn_param_in(pin12),
        .bnn_x_bank_hi(bank12), .bnn_x(x12), .bnn_out(8'h00)
    );

    // Record every bit the datapath chains would shift in.
    always @(negedge clk) begin
        if (bnn_setup) begin q16.push_back(bnn_param_in); nset16++; end
        if (set12)     begin q12.push_back(pin12);        nset12++; end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack_bits(input logic q[$]);
        logic [31:0] v = '0;
        foreach (q[i]) v = {v[30:0], q[i]};
        return v;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_busy"},    32'(busy), 0);
        check({tag, "_loaded"},  32'(loaded), 0);
        check({tag, "_cfg_rdy"}, 32'(cfg_ready), 0);
        check({tag, "_in_rdy"},  32'(in_ready), 0);
        check({tag, "_out_vld"}, 32'(out_valid), 0);
        check({tag, "_out_dat"}, 32'(out_data), 0);
        check({tag, "_setup"},   32'(bnn_setup), 0);
        check({tag, "_pin"},     32'(bnn_param_in), 0);
        check({tag, "_bank"},    32'(bnn_x_bank_hi), 1);
        check({tag, "_x"},       32'(bnn_x), 0);
    endtask

    // Load 0xA5, 0x3C into the 16-bit chain, optionally idling gap cycles before each byte.
    task automatic load16(input string tag, input int gap);
        int n;
        logic [7:0] bytes [2];
        bytes[0] = 8'hA5;
        bytes[1] = 8'h3C;
        q16.delete();
        nset16  = 0;
        gap_bad = 0;
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            n = 0;
            while (!cfg_ready && n < 30) begin tick(); n++; end
            check({tag, "_cfg_rdy_wait"}, 32'(cfg_ready), 1);
            for (int g = 0; g < gap; g++) begin
                tick();
                if (bnn_setup) gap_bad++;
            end
            cfg_valid = 1'b1; cfg_data = bytes[b]; tick(); cfg_valid = 1'b0;
        end
        n = 0;
        while (!loaded && n < 30) begin tick(); n++; end
        tick();
        check({tag, "_loaded"},  32'(loaded), 1);
        check({tag, "_nsetup"},  32'(nset16), 16);
        check({tag, "_bits"},    pack_bits(q16), 32'h0000_A53C);
        check({tag, "_in_rdy"},  32'(in_ready), 1);
        check({tag, "_cfg_rdy"}, 32'(cfg_ready), 0);
        check({tag, "_busy"},    32'(busy), 0);
    endtask

    // Run one inference with the datapath model answering dout; load_start pulsed while busy.
    task automatic infer(input string tag, input logic [7:0] din, input logic [7:0] dout);
        bnn_out  = dout;
        in_valid = 1'b1; in_data = din;
        check({tag, "_in_rdy"}, 32'(in_ready), 1);
        tick();                                      // E0
        in_valid = 1'b0;
        check({tag, "_x_lo"},    32'(bnn_x), 32'(din[3:0]));
        check({tag, "_bank_lo"}, 32'(bnn_x_bank_hi), 0);
        check({tag, "_busy"},    32'(busy), 1);
        load_start = 1'b1;
        tick();                                      // E1
        load_start = 1'b0;
        check({tag, "_x_hi"},    32'(bnn_x), 32'(din[7:4]));
        check({tag, "_bank_hi"}, 32'(bnn_x_bank_hi), 1);
        tick();                                      // E2
        check({tag, "_vld_early"}, 32'(out_valid), 0);
        tick();                                      // E3
        check({tag, "_vld"},  32'(out_valid), 1);
        check({tag, "_data"}, 32'(out_data), 32'(dout));
        bnn_out = ~dout;
        load_start = 1'b1;
        repeat (3) tick();
        load_start = 1'b0;
        check({tag, "_vld_hold"},  32'(out_valid), 1);
        check({tag, "_data_hold"}, 32'(out_data), 32'(dout));
        check({tag, "_no_load"},   32'(cfg_ready), 0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check({tag, "_vld_clr"},   32'(out_valid), 0);
        check({tag, "_idle"},      32'(busy), 0);
        check({tag, "_still_ld"},  32'(loaded), 1);
        check({tag, "_rdy_again"}, 32'(in_ready), 1);
        check({tag, "_keep_data"}, 32'(out_data), 32'(dout));
        check({tag, "_idle_x"},    32'(bnn_x), 32'(din[7:4]));
        check({tag, "_idle_bank"}, 32'(bnn_x_bank_hi), 1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        load_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; bnn_out = '0;
        ld12 = 1'b0; cv12 = 1'b0; cd12 = '0;
        repeat (2) tick();
        check_reset("rst");
        rst_n = 1'b1;
        tick();

        // Inference requests are refused before any load.
        in_valid = 1'b1; in_data = 8'h11;
        repeat (3) tick();
        check("gate_in_rdy", 32'(in_ready), 0);
        check("gate_busy",   32'(busy), 0);
        in_valid = 1'b0;

        load16("load", 0);
        load16("stall", 5);
        check("stall_gap_setup", 32'(gap_bad), 0);

        // 12-bit chain: the second byte contributes only its low nibble.
        q12.delete();
        ld12 = 1'b1; tick(); ld12 = 1'b0;
        check("p12_cfg_rdy0", 32'(cr12), 1);
        cv12 = 1'b1; cd12 = 8'hFF; tick(); cv12 = 1'b0;
        n = 0;
        while (!cr12 && n < 30) begin tick(); n++; end
        check("p12_cfg_rdy1", 32'(cr12), 1);
        cv12 = 1'b1; cd12 = 8'h0F; tick(); cv12 = 1'b0;
        check("p12_cfg_rdy_after", 32'(cr12), 0);
        n = 0;
        while (!loaded12 && n < 30) begin tick(); n++; end
        tick();
        check("p12_loaded",  32'(loaded12), 1);
        check("p12_nsetup",  32'(nset12), 12);
        check("p12_bits",    pack_bits(q12), 32'h0000_0FFF);
        check("p12_cfg_end", 32'(cr12), 0);

        infer("inf1", 8'h5A, 8'hC3);
        tick();
        infer("inf2", 8'h3C, 8'h7E);

        // Reset after seven bits of a new load have been shifted.
        load_start = 1'b1; tick(); load_start = 1'b0;
        n = 0;
        while (!cfg_ready && n < 30) begin tick(); n++; end
        cfg_valid = 1'b1; cfg_data = 8'hA5; tick(); cfg_valid = 1'b0;
        repeat (7) tick();
        check("mid_setup", 32'(bnn_setup), 1);
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        load16("reload", 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bnn_sequencer.md
# bnn_sequencer

Controller that sequences the tiny binary neural network datapath on a single clock. It loads the serial parameter chain from a byte stream: weights and biases of all hidden and output neurons, shifted one bit per cycle under `setup`. It then runs inference requests by writing the 8-bit input vector as two nibbles and returning the 8-bit classification. It sits between a host byte interface and the datapath's `setup` / `param_in` / `x_bank_hi` / `x` / output pins.

## Interface
Parameters:
- `CHAIN_BITS`, default 256: total parameter-chain length in bits. Any value from 1 upward is legal.
- `SETTLE`, default 1: number of cycles waited after the high nibble is written before the output is captured. Must be 1 or more.

Ports:
- `clk` in 1: the single clock. The datapath runs on the same clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `load_start` in 1: pulse that begins a parameter load. Honoured only in IDLE.
- `cfg_valid` in 1, `cfg_ready` out 1, `cfg_data` in 8: parameter byte stream, valid/ready handshake. Bits are shifted out LSB first.
- `in_valid` in 1, `in_ready` out 1, `in_data` in 8: inference input vector, valid/ready handshake.
- `out_valid` out 1, `out_ready` in 1, `out_data` out 8: inference result, valid/ready handshake.
- `busy` out 1: state is not IDLE.
- `loaded` out 1: a complete chain of `CHAIN_BITS` bits has been shifted since the last `load_start` or reset.
- `bnn_setup` out 1, `bnn_param_in` out 1: datapath setup and serial parameter input.
- `bnn_x_bank_hi` out 1, `bnn_x` out 4: datapath nibble input and bank select.
- `bnn_out` in 8: datapath outputs. Only meaningful while `bnn_setup` is 0.

## Operation
States:
- IDLE
- LOAD
- X_LO
- X_HI
- WAIT
- HOLD

IDLE:
- `load_start` → LOAD. Clears `loaded` and the bit counter, and drops any partial byte.
- `in_valid & in_ready` → X_LO. Latches `in_data`.
- `in_ready = loaded & !out_valid`.

LOAD:
- `cfg_ready` is 1 only when the byte shifter is empty and the remaining bit count is greater than 0.
- An accepted byte is shifted out over the following cycles, LSB first, one bit per cycle.
- The datapath chain shifts on every edge where setup is high. Therefore `bnn_setup` is 1 only on cycles that present a real bit on `bnn_param_in`, and 0 while the sequencer waits for a byte.
- The final byte shifts only `CHAIN_BITS mod 8` bits (or 8 if that is 0). Its unused upper bits are discarded.
- After the last bit → IDLE with `loaded` = 1.
- `load_start` and `in_valid` are ignored while in LOAD.

X_LO: drive `bnn_x = in[3:0]` and `bnn_x_bank_hi = 0` for one cycle → X_HI.

X_HI: drive `bnn_x = in[7:4]` and `bnn_x_bank_hi = 1` for one cycle → WAIT.

WAIT:
- Lasts `SETTLE` cycles.
- On the final edge, register `out_data <= bnn_out` and set `out_valid` = 1 → HOLD.

HOLD:
- `out_valid` stays 1 until `out_ready`. Then clear `out_valid` → IDLE.
- `out_data` keeps its value until the next capture.

Idle-safe nibble drive: in every state other than X_LO and X_HI, `bnn_x_bank_hi` = 1 and `bnn_x` = the latched high nibble. The datapath captures x every non-setup cycle, so this rewrite is idempotent.

## Timing
Reset values:
- State IDLE.
- `loaded`, `busy`, `cfg_ready`, `in_ready`, `out_valid` = 0.
- `out_data` = 0.
- `bnn_setup` = 0, `bnn_param_in` = 0.
- `bnn_x_bank_hi` = 1, `bnn_x` = 0, latched input = 0.

Load timing:
- A byte accepted at edge E is shifted at edges E+1 through E+8.
- `cfg_ready` rises again in the cycle after edge E+8.
- The next byte is therefore accepted at E+9 at the earliest.

Inference timing:
- Accept at edge E0.
- Low nibble written at E1, high nibble at E2.
- `out_valid` rises after edge E2+`SETTLE` (E3 by default).
- Earliest next acceptance is one cycle after the `out_ready` handshake.

Reset mid-operation:
- Returns immediately to the reset values above, including `loaded` = 0.
- The datapath keeps its partial chain contents, but a new load is required before inference.

Simultaneous `load_start` and `in_valid` in IDLE: `load_start` wins and `in_valid` is not accepted.

## Structure
- Package `bnn_pkg` holds:
  - state enum `bnn_seq_state_t`;
  - `BNN_IN_BITS` = 8, `BNN_OUT_BITS` = 8, `BNN_NIBBLE` = 4;
  - `BNN_CHAIN_BITS`, the default chain length.
- Sub-module `bnn_param_serializer`: byte-to-bit shifter with valid/ready input, a bit-count limit and a `shift_en` output that drives `bnn_setup`.

## Test plan
- **Load, CHAIN_BITS=16:**
  - Stimulus: `load_start`, then bytes 0xA5 and 0x3C with `cfg_valid` held.
  - Required: `bnn_param_in` bit sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - Required: exactly 16 cycles with `bnn_setup` = 1.
  - Required: `loaded` = 1 afterwards.
- **Stalled load:**
  - Stimulus: insert 5 idle cycles between bytes.
  - Required: `bnn_setup` = 0 during the gap; the bit sequence is unchanged.
- **Partial final byte, CHAIN_BITS=12:**
  - Stimulus: bytes 0xFF, 0x0F.
  - Required: 12 shift cycles; `cfg_ready` = 0 after the second byte; the last 4 bits are 1.
- **Inference:**
  - Stimulus: `in_data` = 0x5A accepted at E0.
  - Required: `bnn_x` = 0xA with `bnn_x_bank_hi` = 0 at E1; `bnn_x` = 0x5 with `bnn_x_bank_hi` = 1 at E2.
  - Required: `out_valid` after E3 with `out_data` equal to `bnn_out` (model-driven, e.g. 0xC3).
  - Required: `out_valid` held while `out_ready` = 0.
- **Gating:**
  - Stimulus: `in_valid` before any load.
  - Required: `in_ready` = 0.
  - Required: `load_start` during inference is ignored.
- **Reset mid-load:**
  - Stimulus: assert `rst_n` low after 7 bits have been shifted.
  - Required: all outputs at their reset values; `loaded` = 0.
  - Required: a full reload then succeeds.
